// File: rtl/serial_subtractor_if.sv
// ---------------------------------------------------------------------------
// serial_subtractor_if
//
// Bundles the request/result signals of the bit-serial subtractor.
//
// Handshake: a request is accepted on the rising edge where start=1 and
// ready=1. start is ignored at every other edge. a and b are sampled only on
// that accepting edge. done is a one-cycle pulse. diff/borrow are valid from
// the done cycle until the next completion.
//
// Signals:
//   start      request strobe                      (master -> slave)
//   a, b       minuend / subtrahend, WIDTH bits    (master -> slave)
//   ready      block idle, can accept              (slave -> master)
//   busy       operation in progress               (slave -> master)
//   done       one-cycle completion pulse          (slave -> master)
//   diff       (a - b) mod 2^WIDTH                 (slave -> master)
//   borrow     1 iff a < b                         (slave -> master)
//   state_dbg  raw FSM state, for debug/checkers   (slave -> master)
// ---------------------------------------------------------------------------
interface serial_subtractor_if #(
    parameter int WIDTH = 4
) ();
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             ready;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] diff;
    logic             borrow;
    logic [1:0]       state_dbg;

    modport master (
        output start, a, b,
        input  ready, busy, done, diff, borrow, state_dbg
    );

    modport slave (
        input  start, a, b,
        output ready, busy, done, diff, borrow, state_dbg
    );
endinterface

// File: rtl/serial_subtractor.sv
// ---------------------------------------------------------------------------
// serial_subtractor
//
// Bit-serial unsigned subtractor. It computes a - b LSB-first, one bit per
// clock, using a full-subtractor cell with a registered borrow. Each
// operation takes WIDTH+2 cycles from accept to the next possible accept.
//
// Ports:
//   clk     rising-edge clock
//   rst     asynchronous, active-high reset
//   io_bus  serial_subtractor_if.slave: start/a/b in,
//           ready/busy/done/diff/borrow/state_dbg out (all registered)
// ---------------------------------------------------------------------------
module serial_subtractor #(
    parameter int WIDTH = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    serial_subtractor_if.slave   io_bus
);

    localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    state_t           r_state;
    // Minuend and result share one register: each cycle the LSB (next
    // minuend bit) is consumed and the new difference bit enters at the MSB.
    // After WIDTH shifts it holds the whole difference.
    logic [WIDTH-1:0] r_a_res;
    logic [WIDTH-1:0] r_b;
    logic             r_br;
    logic [CW-1:0]    r_cnt;
    logic [WIDTH-1:0] r_diff;
    logic             r_borrow;
    logic             r_ready;
    logic             r_busy;
    logic             r_done;

    logic             w_a0;
    logic             w_b0;
    logic             w_d;
    logic             w_br_next;
    logic [WIDTH-1:0] w_res_next;

    // Full-subtractor cell.
    assign w_a0       = r_a_res[0];
    assign w_b0       = r_b[0];
    assign w_d        = w_a0 ^ w_b0 ^ r_br;
    assign w_br_next  = (~w_a0 & w_b0) | (~(w_a0 ^ w_b0) & r_br);
    assign w_res_next = {w_d, r_a_res[WIDTH-1:1]};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= S_IDLE;
            r_a_res  <= '0;
            r_b      <= '0;
            r_br     <= 1'b0;
            r_cnt    <= '0;
            r_diff   <= '0;
            r_borrow <= 1'b0;
            r_ready  <= 1'b1;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (io_bus.start) begin
                        r_a_res <= io_bus.a;
                        r_b     <= io_bus.b;
                        r_br    <= 1'b0;
                        r_cnt   <= '0;
                        r_state <= S_SHIFT;
                        r_ready <= 1'b0;
                        r_busy  <= 1'b1;
                    end
                end

                S_SHIFT: begin
                    r_a_res <= w_res_next;
                    r_b     <= {1'b0, r_b[WIDTH-1:1]};
                    r_br    <= w_br_next;
                    r_cnt   <= r_cnt + CW'(1);
                    // Results are published only here, so diff/borrow stay
                    // stable for the whole SHIFT phase.
                    if (r_cnt == LAST_BIT) begin
                        r_diff   <= w_res_next;
                        r_borrow <= w_br_next;
                        r_state  <= S_DONE;
                        r_busy   <= 1'b0;
                        r_done   <= 1'b1;
                    end
                end

                S_DONE: begin
                    r_state <= S_IDLE;
                    r_done  <= 1'b0;
                    r_ready <= 1'b1;
                end

                default: begin
                    r_state <= S_IDLE;
                    r_ready <= 1'b1;
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                end
            endcase
        end
    end

    assign io_bus.ready     = r_ready;
    assign io_bus.busy      = r_busy;
    assign io_bus.done      = r_done;
    assign io_bus.diff      = r_diff;
    assign io_bus.borrow    = r_borrow;
    assign io_bus.state_dbg = r_state;

endmodule

// File: tb/tb_serial_subtractor.sv
module tb_serial_subtractor;

  logic clk;
  logic rst;

  serial_subtractor_if #(.WIDTH(4)) b4 ();
  serial_subtractor_if #(.WIDTH(8)) b8 ();

  serial_subtractor #(.WIDTH(4)) dut4 (
    .clk    (clk),
    .rst    (rst),
    .io_bus (b4.slave)
  );

  serial_subtractor #(.WIDTH(8)) dut8 (
    .clk    (clk),
    .rst    (rst),
    .io_bus (b8.slave)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_assert = 0;
  int n_fail   = 0;

  // scoreboard: {borrow, diff zero-extended to 8 bits}
  logic [8:0] exp_q[$];

  initial begin
    #3_000_000;
    $display("FAIL watchdog: observed no end of test, expected finish before 3ms");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // reference model: plain integer subtraction, borrow = went negative
  function automatic logic [8:0] model(input int w, input int a, input int b);
    int d;
    logic bo;
    d  = a - b;
    bo = (d < 0);
    if (d < 0) d = d + (1 << w);
    return {bo, 8'(d)};
  endfunction

  function automatic logic s_ready(input int w);
    return (w == 8) ? b8.ready : b4.ready;
  endfunction
  function automatic logic s_busy(input int w);
    return (w == 8) ? b8.busy : b4.busy;
  endfunction
  function automatic logic s_done(input int w);
    return (w == 8) ? b8.done : b4.done;
  endfunction
  function automatic logic [8:0] s_res(input int w);
    return (w == 8) ? {b8.borrow, b8.diff} : {b4.borrow, 4'b0000, b4.diff};
  endfunction

  // driver
  task automatic drive(input int w, input logic s, input int a, input int b);
    if (w == 8) begin
      b8.start = s;
      b8.a     = 8'(a);
      b8.b     = 8'(b);
    end else begin
      b4.start = s;
      b4.a     = 4'(a);
      b4.b     = 4'(b);
    end
  endtask

  // One operation, issued at the first ready sample. Called and returning
  // on a negedge. With disturb=1, start is held high and a/b are changed to
  // 1/14 for the whole SHIFT phase.
  task automatic op(input int w, input int a, input int b, input bit disturb);
    int k;
    int busy_n;
    int hold_bad;
    logic [8:0] prev;
    logic [8:0] exp;
    k = 0;
    while (!s_ready(w) && k < 50) begin
      @(negedge clk);
      k++;
    end
    chk("ready_before_start", s_ready(w), 1);
    prev = s_res(w);
    exp_q.push_back(model(w, a, b));
    drive(w, 1'b1, a, b);
    @(negedge clk);                       // edge 0 accepted
    if (disturb) drive(w, 1'b1, 1, 14);
    else         drive(w, 1'b0, int'($urandom), int'($urandom));
    k = 0;
    busy_n = 0;
    hold_bad = 0;
    while (k < 50 && !s_done(w)) begin
      if (s_busy(w)) busy_n++;
      if (s_res(w) !== prev) hold_bad++;
      k++;
      @(negedge clk);
    end
    drive(w, 1'b0, 0, 0);
    chk("done_latency", k, w);
    chk("busy_len", busy_n, w);
    chk("hold_during_shift", hold_bad, 0);
    exp = exp_q.pop_front();
    chk("result", s_res(w), exp);
    @(negedge clk);
    chk("done_width", s_done(w), 0);
    chk("ready_return", s_ready(w), 1);
  endtask

  initial begin
    int dn;
    logic [8:0] held;

    rst = 1'b1;
    drive(4, 1'b0, 0, 0);
    drive(8, 1'b0, 0, 0);
    #12;
    // reset state
    chk("rst_ready", b4.ready, 1);
    chk("rst_busy", b4.busy, 0);
    chk("rst_done", b4.done, 0);
    chk("rst_res", s_res(4), 0);
    chk("rst_res8", s_res(8), 0);
    chk("rst_ready8", b8.ready, 1);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // basic subtraction and underflows
    op(4, 9, 3, 0);
    chk("basic_val", s_res(4), {1'b0, 8'h06});
    op(4, 3, 9, 0);
    chk("under_3_9", s_res(4), {1'b1, 8'h0A});
    op(4, 0, 15, 0);
    chk("under_0_15", s_res(4), {1'b1, 8'h01});
    op(4, 5, 5, 0);
    chk("equal_5_5", s_res(4), {1'b0, 8'h00});

    // ignored start and input changes during SHIFT
    op(4, 12, 4, 1);
    chk("disturb_val", s_res(4), {1'b0, 8'h08});
    dn = 0;
    repeat (10) begin
      if (b4.done) dn++;
      @(negedge clk);
    end
    chk("no_second_done", dn, 0);
    chk("disturb_hold", s_res(4), {1'b0, 8'h08});

    // reset mid-operation
    drive(4, 1'b1, 2, 7);
    @(posedge clk);                       // edge 0
    #1 drive(4, 1'b0, 0, 0);
    @(posedge clk);                       // edge 1
    @(posedge clk);                       // edge 2
    #3 rst = 1'b1;
    #1;
    chk("mid_rst_ready", b4.ready, 1);
    chk("mid_rst_busy", b4.busy, 0);
    chk("mid_rst_done", b4.done, 0);
    chk("mid_rst_res", s_res(4), 0);
    dn = 0;
    repeat (3) begin
      @(negedge clk);
      if (b4.done) dn++;
    end
    rst = 1'b0;
    repeat (6) begin
      @(negedge clk);
      if (b4.done) dn++;
    end
    chk("mid_rst_no_done", dn, 0);
    op(4, 7, 2, 0);
    chk("after_rst_val", s_res(4), {1'b0, 8'h05});

    // output hold while idle
    held = s_res(4);
    repeat (20) begin
      @(negedge clk);
      chk("idle_hold_res", s_res(4), held);
      chk("idle_hold_done", b4.done, 0);
    end

    // exhaustive, back-to-back
    for (int a = 0; a < 16; a++)
      for (int b = 0; b < 16; b++)
        op(4, a, b, 0);

    // random, with random idle gaps
    for (int i = 0; i < 40; i++) begin
      repeat ($urandom_range(0, 3)) @(negedge clk);
      op(4, int'($urandom_range(0, 15)), int'($urandom_range(0, 15)), 0);
    end

    // WIDTH=8 corner and random
    op(8, 8'h00, 8'h01, 0);
    chk("w8_corner", s_res(8), {1'b1, 8'hFF});
    op(8, 8'hFF, 8'h00, 0);
    for (int i = 0; i < 30; i++)
      op(8, int'($urandom_range(0, 255)), int'($urandom_range(0, 255)), 0);

    chk("sb_empty", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/serial_subtractor.md
# serial_subtractor

Bit-serial unsigned subtractor, the inverse arithmetic companion to the team's half-adder datapath. It accepts two WIDTH-bit operands on a start strobe and computes a − b LSB-first, one bit per clock. The core is a half-subtractor/full-subtractor cell with a registered borrow. It returns the registered difference and the final borrow with a one-cycle done pulse. It sits alongside the adder blocks as the area-cheap subtract path for control logic that can tolerate WIDTH-cycle latency.

## Interface
- WIDTH, default 4: operand and result width in bits; legal range 2..32.

- clk  in  1  single clock; all state changes on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  request; sampled only when ready=1.
- a  in  WIDTH  minuend; sampled on the accepting edge only.
- b  in  WIDTH  subtrahend; sampled on the accepting edge only.
- ready  out  1  high iff the FSM is in IDLE.
- busy  out  1  high iff the FSM is in SHIFT.
- done  out  1  one-cycle pulse, high iff the FSM is in DONE.
- diff  out  WIDTH  (a − b) mod 2^WIDTH of the last completed operation.
- borrow  out  1  1 iff a < b (unsigned) for the last completed operation.

## Operation
- FSM states are IDLE, SHIFT and DONE. The encoding is free; the three outputs ready, busy and done decode the state directly.
- **Reset:**
  - rst=1 forces state=IDLE immediately (asynchronous).
  - It clears the operand shift registers, the borrow flop, the bit counter, diff and borrow.
  - Output values during and after reset: ready=1, busy=0, done=0, diff=0, borrow=0.
- **IDLE:**
  - If start=1 at an edge: load a and b into the shift registers, clear the borrow flop, clear the counter, and go to SHIFT.
  - Otherwise remain in IDLE; diff and borrow hold.
- **SHIFT:** on each edge:
  - d = a0 ^ b0 ^ br
  - br_next = (~a0 & b0) | (~(a0 ^ b0) & br)
  - Shift d into the MSB of the internal result register (right shift).
  - Right-shift both operand registers.
  - Increment the counter.
  - On the edge that processes bit WIDTH−1: go to DONE, copy the complete internal result into diff, and copy br_next into borrow.
- **DONE:** the state lasts exactly one cycle, then the FSM returns to IDLE unconditionally.
- **Start outside IDLE:** start=1 in SHIFT or DONE is ignored. It is neither queued nor allowed to corrupt the operation in flight.
- **Input changes:** changes on a and b after the accepting edge have no effect.
- **Output stability:** diff and borrow change only on the edge entering DONE, or on reset. They are stable during SHIFT and remain valid until the next completion.
- **Reset mid-operation:** aborts the operation; no done pulse is produced; the outputs clear to 0.
- **Arithmetic:** unsigned modular subtraction. Equivalently, {borrow, diff} = {1'b0, a} − {1'b0, b} taken as WIDTH+1 bits, two's complement.

## Timing
- Let edge 0 be the edge on which start is accepted (ready=1, start=1).
- Edges 1..WIDTH process bits 0..WIDTH−1.
- After edge WIDTH: state=DONE, done=1, and the new diff/borrow are visible.
- After edge WIDTH+1: state=IDLE, done=0, ready=1.
- The earliest next accept is edge WIDTH+2, so one operation completes every WIDTH+2 cycles.
- busy is high after edges 0..WIDTH−1, i.e. for exactly WIDTH cycles.
- All outputs are registered; there are no combinational paths from inputs to outputs.
- Asynchronous reset assertion takes effect without a clock edge.
- Reset deassertion is synchronous to clk externally; the block does no internal synchronization.

## Test plan
- **Basic subtraction:** WIDTH=4, a=9, b=3, start for one cycle → done exactly 4 cycles after the accepting edge; diff=6, borrow=0; ready returns the following cycle.
- **Underflow cases:**
  - a=3, b=9 → diff=4'hA, borrow=1.
  - a=0, b=15 → diff=1, borrow=1.
  - a=5, b=5 → diff=0, borrow=0.
- **Exhaustive check:** all 256 (a, b) pairs at WIDTH=4, issued back-to-back at the earliest ready → every result matches {borrow, diff} = {0, a} − {0, b}. Check the done pulse width (exactly 1) and the busy length (exactly 4) every time.
- **Ignored start and input stability:** accept a=12, b=4, then during SHIFT hold start=1 and change a=1, b=14 → exactly one done; diff=8, borrow=0; no second operation starts until ready.
- **Reset mid-operation:** accept a=2, b=7, assert rst asynchronously midway through SHIFT cycle 2 → immediately ready=1, busy=0, diff=0, borrow=0; no done pulse. After release, a=7, b=2 → diff=5, borrow=0.
- **Output hold and WIDTH=8 corner:**
  - After a completion, hold start=0 for 20 cycles → diff and borrow unchanged, done stays 0.
  - Rerun with WIDTH=8, a=8'h00, b=8'h01 → diff=8'hFF, borrow=1, done after 8 cycles.
